// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver (scan code set 2) that turns make/break codes into
// a 21-bit held-note vector for the tone generator.
// Optional build macro: PS2_PARITY_CHECK_EN (enables odd-parity checking).
module ps2_key_decoder #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [20:0] key,
  output logic        code_valid,
  output logic [7:0]  code,
  output logic        frame_err
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          filt;
  logic [FW-1:0] fcnt;
  logic [TW-1:0] tcnt;
  logic          fall_c;
  logic          timeout_c;
  logic          data_bit;
  logic          parity_ok_c;

  logic [1:0]  state, state_next;
  logic [7:0]  shift, shift_next;
  logic [2:0]  bcnt, bcnt_next;
  logic        brk, brk_next;
  logic        ext, ext_next;
  logic [20:0] key_next;
  logic        accept_c;
  logic        err_c;
  logic        hit_c;
  logic [4:0]  idx_c;

  // Two-flop synchronisers for the asynchronous PS/2 pins (idle level high)
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  assign data_bit = data_sync[1];

  // Glitch filter: level follows the pin only after FILTER_LEN stable cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      filt <= 1'b1;
      fcnt <= '0;
    end else if (clk_sync[1] != filt) begin
      if (fcnt == FW'(FILTER_LEN - 1)) begin
        filt <= clk_sync[1];
        fcnt <= '0;
      end else begin
        fcnt <= fcnt + FW'(1);
      end
    end else begin
      fcnt <= '0;
    end
  end

  // Falling edge is flagged in the same cycle the filtered level drops
  assign fall_c = filt & ~clk_sync[1] & (fcnt == FW'(FILTER_LEN - 1));

  // Mid-frame watchdog: counts cycles since the last falling edge
  always_ff @(posedge clk) begin
    if (rst || fall_c || state == S_IDLE) begin
      tcnt <= '0;
    end else if (tcnt != TW'(TIMEOUT_CYCLES)) begin
      tcnt <= tcnt + TW'(1);
    end
  end

  assign timeout_c = (state != S_IDLE) && (tcnt == TW'(TIMEOUT_CYCLES));

`ifdef PS2_PARITY_CHECK_EN
  logic par;

  // Capture the parity bit for the odd-parity check at the stop bit
  always_ff @(posedge clk) begin
    if (rst) begin
      par <= 1'b0;
    end else if (fall_c && state == S_PARITY) begin
      par <= data_bit;
    end
  end

  assign parity_ok_c = ^{shift, par};
`else
  // Parity bit is consumed by the FSM but never stored or checked
  assign parity_ok_c = 1'b1;
`endif

  // Receive FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and frame acceptance, one action per filtered falling edge
  always_comb begin
    state_next = state;
    shift_next = shift;
    bcnt_next  = bcnt;
    accept_c   = 1'b0;
    err_c      = 1'b0;
    if (timeout_c) begin
      state_next = S_IDLE;
      err_c      = 1'b1;
    end else if (fall_c) begin
      case (state)
        S_IDLE: begin
          if (!data_bit) begin
            state_next = S_DATA;
            bcnt_next  = 3'd0;
          end
        end
        S_DATA: begin
          shift_next = {data_bit, shift[7:1]};
          bcnt_next  = bcnt + 3'd1;
          if (bcnt == 3'd7) begin
            state_next = S_PARITY;
          end
        end
        S_PARITY: begin
          state_next = S_STOP;
        end
        default: begin
          state_next = S_IDLE;
          if (data_bit && parity_ok_c) begin
            accept_c = 1'b1;
          end else begin
            err_c = 1'b1;
          end
        end
      endcase
    end
  end

  // Scan code to note index lookup
  always_comb begin
    hit_c = 1'b1;
    idx_c = 5'd0;
    case (shift)
      8'h1C: idx_c = 5'd0;
      8'h1B: idx_c = 5'd1;
      8'h23: idx_c = 5'd2;
      8'h2B: idx_c = 5'd3;
      8'h34: idx_c = 5'd4;
      8'h33: idx_c = 5'd5;
      8'h3B: idx_c = 5'd6;
      8'h15: idx_c = 5'd7;
      8'h1D: idx_c = 5'd8;
      8'h24: idx_c = 5'd9;
      8'h2D: idx_c = 5'd10;
      8'h2C: idx_c = 5'd11;
      8'h35: idx_c = 5'd12;
      8'h3C: idx_c = 5'd13;
      8'h16: idx_c = 5'd14;
      8'h1E: idx_c = 5'd15;
      8'h26: idx_c = 5'd16;
      8'h25: idx_c = 5'd17;
      8'h2E: idx_c = 5'd18;
      8'h36: idx_c = 5'd19;
      8'h3D: idx_c = 5'd20;
      default: hit_c = 1'b0;
    endcase
  end

  // Make/break/extended decode of an accepted byte; timeout drops prefixes
  always_comb begin
    key_next = key;
    brk_next = brk;
    ext_next = ext;
    if (accept_c) begin
      case (shift)
        8'hF0: brk_next = 1'b1;
        8'hE0: ext_next = 1'b1;
        8'hAA, 8'h00, 8'hFF: begin
          key_next = '0;
          brk_next = 1'b0;
          ext_next = 1'b0;
        end
        default: begin
          if (!ext && hit_c) begin
            key_next[idx_c] = ~brk;
          end
          brk_next = 1'b0;
          ext_next = 1'b0;
        end
      endcase
    end
    if (timeout_c) begin
      brk_next = 1'b0;
      ext_next = 1'b0;
    end
  end

  // Shift register, bit counter and prefix flags
  always_ff @(posedge clk) begin
    if (rst) begin
      shift <= '0;
      bcnt  <= '0;
      brk   <= 1'b0;
      ext   <= 1'b0;
    end else begin
      shift <= shift_next;
      bcnt  <= bcnt_next;
      brk   <= brk_next;
      ext   <= ext_next;
    end
  end

  // Registered outputs, updated one cycle after the stop-bit edge
  always_ff @(posedge clk) begin
    if (rst) begin
      key        <= '0;
      code       <= '0;
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      key        <= key_next;
      code_valid <= accept_c;
      frame_err  <= err_c;
      if (accept_c) begin
        code <= shift;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed scenarios plus randomized
// frames checked against a scan-code level model of held keys.
module tb_ps2_key_decoder;

  localparam int unsigned TMO = 1000;

`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [20:0] key;
  logic        code_valid;
  logic [7:0]  code;
  logic        frame_err;

  int checks = 0;
  int errors = 0;

  int          cv_cnt = 0;
  int          fe_cnt = 0;
  logic [7:0]  last_code = '0;
  logic [20:0] key_at_cv = '0;

  logic [20:0] m_key = '0;
  bit          m_brk = 1'b0;
  bit          m_ext = 1'b0;

  logic [7:0] note_code [21] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B,
                                 8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C,
                                 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D};

  ps2_key_decoder #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key(key), .code_valid(code_valid), .code(code), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Pulse monitor sampled away from the active edge
  always @(negedge clk) begin
    if (code_valid) begin
      cv_cnt++;
      last_code = code;
      key_at_cv = key;
    end
    if (frame_err) fe_cnt++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int note_of(input logic [7:0] b);
    for (int i = 0; i < 21; i++) if (note_code[i] == b) return i;
    return -1;
  endfunction

  // Reference model: effect of one accepted byte on held keys and prefixes
  task automatic model_byte(input logic [7:0] b);
    int n;
    if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hAA || b == 8'h00 || b == 8'hFF) begin
      m_key = '0; m_brk = 1'b0; m_ext = 1'b0;
    end else begin
      n = note_of(b);
      if (!m_ext && n >= 0) m_key[n] = ~m_brk;
      m_brk = 1'b0; m_ext = 1'b0;
    end
  endtask

  task automatic ps2_bits(input logic [10:0] v, input int lo, input int hi, input bit glitch);
    int half;
    int g;
    for (int i = lo; i <= hi; i++) begin
      half = int'($urandom_range(32, 20));
      @(negedge clk); ps2_data = v[i];
      if (glitch) begin
        repeat (13) @(negedge clk);
        g = int'($urandom_range(5, 1));
        ps2_clk = 1'b0; repeat (g) @(negedge clk); ps2_clk = 1'b1;
        repeat (half - 13 - g) @(negedge clk);
      end else repeat (half) @(negedge clk);
      ps2_clk = 1'b0;
      if (glitch) begin
        repeat (13) @(negedge clk);
        g = int'($urandom_range(5, 1));
        ps2_clk = 1'b1; repeat (g) @(negedge clk); ps2_clk = 1'b0;
        repeat (half - 13 - g) @(negedge clk);
      end else repeat (half) @(negedge clk);
      ps2_clk = 1'b1;
    end
    repeat (4) @(negedge clk);
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit par_ok, input bit stop);
    logic p;
    p = par_ok ? ~(^b) : (^b);
    return {stop, p, b, 1'b0};
  endfunction

  task automatic send_frame(input logic [7:0] b, input bit par_ok, input bit stop, input bit glitch);
    ps2_bits(mk_frame(b, par_ok, stop), 0, 10, glitch);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk); rst = 1'b0;
    m_key = '0; m_brk = 1'b0; m_ext = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (key !== 21'h0) begin errors++; $display("FAIL reset_key got %h want 000000", key); end
    checks++; if (code !== 8'h00) begin errors++; $display("FAIL reset_code got %h want 00", code); end
    checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL reset_cv got %b want 0", code_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_fe got %b want 0", frame_err); end
  endtask

  task automatic test_single_make();
    int cv0;
    cv0 = cv_cnt;
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    checks++; if (cv_cnt - cv0 !== 1) begin errors++; $display("FAIL single_cv got %0d want 1", cv_cnt - cv0); end
    checks++; if (last_code !== 8'h1C) begin errors++; $display("FAIL single_code got %h want 1c", last_code); end
    checks++; if (key_at_cv !== 21'h000001) begin errors++; $display("FAIL single_key_at_pulse got %h want 000001", key_at_cv); end
    checks++; if (key !== 21'h000001) begin errors++; $display("FAIL single_key got %h want 000001", key); end
  endtask

  task automatic test_break_sequence();
    int cv0;
    do_reset();
    cv0 = cv_cnt;
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    send_frame(8'h16, 1'b1, 1'b1, 1'b0);
    checks++; if (key !== 21'h004001) begin errors++; $display("FAIL brk_two_keys got %h want 004001", key); end
    send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
    checks++; if (key !== 21'h004001) begin errors++; $display("FAIL brk_prefix got %h want 004001", key); end
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    checks++; if (key !== 21'h004000) begin errors++; $display("FAIL brk_release got %h want 004000", key); end
    checks++; if (cv_cnt - cv0 !== 4) begin errors++; $display("FAIL brk_pulses got %0d want 4", cv_cnt - cv0); end
  endtask

  task automatic test_extended();
    do_reset();
    send_frame(8'h15, 1'b1, 1'b1, 1'b0);
    send_frame(8'h15, 1'b1, 1'b1, 1'b0);
    checks++; if (key !== 21'h000080) begin errors++; $display("FAIL ext_typematic got %h want 000080", key); end
    send_frame(8'hE0, 1'b1, 1'b1, 1'b0);
    send_frame(8'h75, 1'b1, 1'b1, 1'b0);
    checks++; if (key !== 21'h000080) begin errors++; $display("FAIL ext_ignored got %h want 000080", key); end
    send_frame(8'h1D, 1'b1, 1'b1, 1'b0);
    checks++; if (key !== 21'h000180) begin errors++; $display("FAIL ext_cleared got %h want 000180", key); end
  endtask

  task automatic test_errors();
    int cv0;
    int fe0;
    logic [10:0] v;
    do_reset();
    cv0 = cv_cnt; fe0 = fe_cnt;
    send_frame(8'h1B, 1'b1, 1'b0, 1'b0);
    checks++; if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL stop_err_fe got %0d want 1", fe_cnt - fe0); end
    checks++; if (cv_cnt - cv0 !== 0) begin errors++; $display("FAIL stop_err_cv got %0d want 0", cv_cnt - cv0); end
    checks++; if (key !== 21'h0) begin errors++; $display("FAIL stop_err_key got %h want 000000", key); end
    send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
    cv0 = cv_cnt; fe0 = fe_cnt;
    v = mk_frame(8'h2B, 1'b1, 1'b1);
    ps2_bits(v, 0, 5, 1'b0);
    repeat (TMO + 200) @(negedge clk);
    checks++; if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL timeout_fe got %0d want 1", fe_cnt - fe0); end
    checks++; if (cv_cnt - cv0 !== 0) begin errors++; $display("FAIL timeout_cv got %0d want 0", cv_cnt - cv0); end
    send_frame(8'h1B, 1'b1, 1'b1, 1'b0);
    checks++; if (key !== 21'h000002) begin errors++; $display("FAIL timeout_recover got %h want 000002", key); end
  endtask

  task automatic test_parity();
    int cv0;
    int fe0;
    do_reset();
    cv0 = cv_cnt; fe0 = fe_cnt;
    send_frame(8'h24, 1'b0, 1'b1, 1'b0);
    checks++; if (key[9] !== ~PAR_EN) begin errors++; $display("FAIL parity_key9 got %b want %b", key[9], ~PAR_EN); end
    checks++; if (fe_cnt - fe0 !== int'(PAR_EN)) begin errors++; $display("FAIL parity_fe got %0d want %0d", fe_cnt - fe0, PAR_EN); end
    checks++; if (cv_cnt - cv0 !== int'(!PAR_EN)) begin errors++; $display("FAIL parity_cv got %0d want %0d", cv_cnt - cv0, !PAR_EN); end
  endtask

  task automatic test_glitch();
    do_reset();
    send_frame(8'h3D, 1'b1, 1'b1, 1'b1);
    checks++; if (last_code !== 8'h3D) begin errors++; $display("FAIL glitch_code got %h want 3d", last_code); end
    send_frame(8'h2C, 1'b1, 1'b1, 1'b1);
    checks++; if (key !== 21'h100800) begin errors++; $display("FAIL glitch_key got %h want 100800", key); end
  endtask

  task automatic test_self_test_clear();
    do_reset();
    for (int i = 0; i < 21; i++) send_frame(note_code[i], 1'b1, 1'b1, 1'b0);
    checks++; if (key !== 21'h1FFFFF) begin errors++; $display("FAIL all_keys got %h want 1fffff", key); end
    send_frame(8'hAA, 1'b1, 1'b1, 1'b0);
    checks++; if (key !== 21'h0) begin errors++; $display("FAIL aa_clear got %h want 000000", key); end
  endtask

  task automatic test_reset_midframe();
    int cv0;
    logic [10:0] v;
    do_reset();
    send_frame(8'h23, 1'b1, 1'b1, 1'b0);
    v = mk_frame(8'h34, 1'b1, 1'b1);
    ps2_bits(v, 0, 3, 1'b0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    checks++; if (key !== 21'h0 || code !== 8'h00 || code_valid !== 1'b0 || frame_err !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs got key=%h code=%h cv=%b fe=%b want all 0", key, code, code_valid, frame_err);
    end
    rst = 1'b0;
    m_key = '0; m_brk = 1'b0; m_ext = 1'b0;
    cv0 = cv_cnt;
    ps2_bits(v, 4, 10, 1'b0);
    repeat (TMO + 200) @(negedge clk);
    checks++; if (cv_cnt - cv0 !== 0) begin errors++; $display("FAIL midrst_cv got %0d want 0", cv_cnt - cv0); end
    checks++; if (key !== 21'h0) begin errors++; $display("FAIL midrst_key got %h want 000000", key); end
  endtask

  task automatic test_random();
    int cv0;
    int fe0;
    int sel;
    logic [7:0] b;
    bit par_ok;
    bit stop;
    bit valid;
    do_reset();
    for (int n = 0; n < 30; n++) begin
      sel = int'($urandom_range(99, 0));
      if (sel < 50) b = note_code[$urandom_range(20, 0)];
      else if (sel < 70) b = 8'hF0;
      else if (sel < 80) b = 8'hE0;
      else b = 8'($urandom);
      par_ok = ($urandom_range(9, 0) != 0);
      stop   = ($urandom_range(9, 0) != 0);
      valid  = stop && (par_ok || !PAR_EN);
      cv0 = cv_cnt; fe0 = fe_cnt;
      send_frame(b, par_ok, stop, $urandom_range(2, 0) == 0);
      if (valid) model_byte(b);
      checks++; if (cv_cnt - cv0 !== int'(valid)) begin errors++; $display("FAIL rnd%0d_cv byte %h got %0d want %0d", n, b, cv_cnt - cv0, valid); end
      checks++; if (fe_cnt - fe0 !== int'(!valid)) begin errors++; $display("FAIL rnd%0d_fe byte %h got %0d want %0d", n, b, fe_cnt - fe0, !valid); end
      checks++; if (key !== m_key) begin errors++; $display("FAIL rnd%0d_key byte %h got %h want %h", n, b, key, m_key); end
      if (valid) begin
        checks++; if (last_code !== b) begin errors++; $display("FAIL rnd%0d_code got %h want %h", n, last_code, b); end
        checks++; if (key_at_cv !== m_key) begin errors++; $display("FAIL rnd%0d_key_at_pulse got %h want %h", n, key_at_cv, m_key); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_make();
    test_break_sequence();
    test_extended();
    test_errors();
    test_parity();
    test_glitch();
    test_self_test_clear();
    test_random();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Receives PS/2 keyboard frames (scan code set 2) and decodes make and break codes into a held-key vector.
- The vector drives the 21-key tone generator: bit 0 = C3 through bit 20 = B5, one bit per note, 1 while the key is held.
- Sits between the board PS/2 pins and the tone generator's key input. Single clock domain on clk.

Parameters:
- FILTER_LEN, 8: cycles ps2_clk must be stable after synchronisation before its filtered level changes.
- TIMEOUT_CYCLES, 200000: cycles with no filtered ps2_clk falling edge, mid-frame, before the frame is aborted (2 ms at 100 MHz).

Ports:
- clk  input  1  system clock (100 MHz nominal).
- rst  input  1  synchronous, active-high reset.
- ps2_clk  input  1  raw PS/2 clock from the pin, asynchronous.
- ps2_data  input  1  raw PS/2 data from the pin, asynchronous.
- key  output  21  held-note vector; bit i = 1 while note i is held.
- code_valid  output  1  one-cycle pulse when a frame is accepted.
- code  output  8  last accepted scan byte; valid when code_valid = 1, held otherwise.
- frame_err  output  1  one-cycle pulse on a framing, parity or timeout error.

Behaviour:

Reset and input conditioning:
- Reset (rst sampled high on a clk edge): key = 0, code = 0, code_valid = 0, frame_err = 0, FSM = IDLE, break/extended flags = 0, filter and timeout counters = 0, filtered clock level = 1.
- Reset mid-frame discards the partial frame; nothing is reported for it.
- ps2_clk and ps2_data each pass through a 2-flop synchroniser.
- Filtered clock level changes only after the synchronised ps2_clk differs from it for FILTER_LEN consecutive cycles.
- A falling edge is a filtered 1->0 transition. Data is sampled (synchronised ps2_data) in that same cycle.

Receive FSM, one action per falling edge:
- IDLE: data = 0 -> DATA with bit count 0. Data = 1 -> stay IDLE, no error.
- DATA: shift in LSB first. After the 8th bit -> PARITY.
- PARITY: capture the parity bit -> STOP.
- STOP: data = 1 and frame valid -> accept the byte and go to IDLE. Data = 0 -> frame_err pulse, byte discarded, go to IDLE.
- Timeout: in any state other than IDLE, if the idle-edge counter reaches TIMEOUT_CYCLES -> IDLE, frame_err pulse, partial frame discarded, break/extended flags cleared. The counter resets on every falling edge.

Acceptance timing:
- code and code_valid are registered: the pulse occurs in the cycle after the stop-bit edge.
- key updates in that same cycle. Latency is 1 clk from the stop-bit edge to key.

Decode, per accepted byte:
- 0xF0: set break flag; key unchanged.
- 0xE0: set extended flag; key unchanged.
- 0xAA (self-test pass), 0x00 or 0xFF (overrun/error): key cleared to 0, flags cleared.
- Any other byte with extended = 1: key unchanged, flags cleared (keypad and arrow keys are ignored).
- Any other byte with extended = 0: if mapped, key[i] = ~break; always clear flags afterwards. Unmapped bytes leave key unchanged.
- Map, bit:code:
  - 0:1C(a), 1:1B(s), 2:23(d), 3:2B(f), 4:34(g), 5:33(h), 6:3B(j)
  - 7:15(q), 8:1D(w), 9:24(e), 10:2D(r), 11:2C(t), 12:35(y), 13:3C(u)
  - 14:16(1), 15:1E(2), 16:26(3), 17:25(4), 18:2E(5), 19:36(6), 20:3D(7)
- Typematic repeats of a held key's make code leave key unchanged (bit already 1).
- Multiple bits may be 1 at once. Each bit changes only on its own code.
- An error frame (frame_err) does not change key or the flags, except that a timeout clears the flags.

Optional Feature:
- Macro: PS2_PARITY_CHECK_EN.
- Defined: a frame is valid only if the 8 data bits plus the parity bit have odd parity. On a parity failure at STOP: frame_err pulse, byte discarded, no code_valid, key unchanged.
- Undefined: the parity bit is captured but ignored; any frame with stop = 1 is accepted.

Test Plan:
- Reset, then frame 0x1C with correct parity and stop -> code_valid pulse, code = 0x1C, key = 0x000001 one cycle after the stop edge.
- 0x1C, 0x16, then F0 1C -> key = 0x004001 after the second byte, then 0x004000 after the break completes. Exactly 4 code_valid pulses.
- E0 75 with key = 0x000080 held -> key unchanged at 0x000080. Next byte 0x1D -> key = 0x000180 (extended flag was cleared).
- Frame with stop bit = 0 -> frame_err pulse, no code_valid, key unchanged. Stop ps2_clk after 5 data bits for more than TIMEOUT_CYCLES -> frame_err pulse, FSM returns to IDLE, and the next full frame 0x1B decodes to key[1] = 1.
- With PS2_PARITY_CHECK_EN defined, frame 0x24 with even parity -> frame_err pulse and key[9] stays 0. Without the macro, the same frame -> key[9] = 1.
- Glitches on ps2_clk shorter than FILTER_LEN cycles during a frame -> no extra bits shifted and the byte decodes correctly. With key = 0x1FFFFF, frame 0xAA -> key = 0. Assert rst mid-frame -> all outputs 0 and the remainder of that frame produces no code_valid.
